exception_controller: RTL

Pipeline exception/interrupt arbiter directly upstream of the CP0 register block. Each cycle it examines the instruction in the M stage (its carried exception code, delay-slot flag, ERET flag) and the six external device interrupt lines, and decides whether to take an exception or interrupt. It produces the write commands CP0 needs (Cause, EPC, SR.EXL), flushes the pipeline and redirects fetch to the handler or back to EPC. A small state machine tracks handler entry and exit so that flushed slots are never re-arbitrated.

---
 rtl/exc_pkg.sv | 39 +++
 rtl/int_synchronizer.sv | 26 ++
 rtl/exception_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared constants, state encoding and Cause packing for the exception controller.
package exc_pkg;

    localparam int          IP_WIDTH           = 6;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int BD_POS  = 31;
    localparam int IP_MSB  = 15;
    localparam int IP_LSB  = 10;
    localparam int EXC_MSB = 6;
    localparam int EXC_LSB = 2;
    localparam int EXL_POS = 1;
    localparam int IE_POS  = 0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DRAIN_IN  = 2'd1,
        HANDLER   = 2'd2,
        DRAIN_OUT = 2'd3
    } state_t;

    function automatic logic [31:0] pack_cause(input logic bd,
                                               input logic [IP_WIDTH-1:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] c;
        c                   = '0;
        c[BD_POS]           = bd;
        c[IP_MSB:IP_LSB]    = ip;
        c[EXC_MSB:EXC_LSB]  = exc;
        return c;
    endfunction

endpackage

// File: rtl/int_synchronizer.sv
// Two-flop per-bit synchronizer for device interrupt lines; only built when
// HW_INT_SYNC_EN is defined.
`ifdef HW_INT_SYNC_EN
module int_synchronizer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/exception_controller.sv
// Exception/interrupt arbiter in front of CP0: writes Cause/EPC/EXL, flushes and
// redirects fetch. Define HW_INT_SYNC_EN to put a two-flop synchronizer on hw_int.
module exception_controller
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEFAULT,
    parameter int          HW_INT_WIDTH = IP_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [HW_INT_WIDTH-1:0] hw_int,
    input  logic [31:0]             sr_value,
    input  logic [31:0]             epc_value,
    input  logic                    m_valid,
    input  logic [31:0]             m_pc,
    input  logic [4:0]              m_exc_code,
    input  logic                    m_bd,
    input  logic                    m_eret,
    output logic [31:0]             cause_wdata,
    output logic                    cause_we,
    output logic [31:0]             epc_wdata,
    output logic                    epc_we,
    output logic                    exl_set,
    output logic                    exl_clr,
    output logic                    flush,
    output logic                    redirect,
    output logic [31:0]             redirect_pc
);

    state_t                  state, state_next;
    logic [HW_INT_WIDTH-1:0] ip_src, ip, cause_ip;
    logic                    held_bd;
    logic [4:0]              held_exc;
    logic                    int_req, take;
    logic                    unused_sr;

`ifdef HW_INT_SYNC_EN
    int_synchronizer #(.WIDTH(HW_INT_WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (hw_int),
        .q     (ip_src)
    );
`else
    assign ip_src = hw_int;
`endif

    assign int_req   = (|(ip & sr_value[IP_MSB:IP_LSB])) & sr_value[IE_POS] & ~sr_value[EXL_POS];
    assign unused_sr = ^{sr_value[31:16], sr_value[9:2]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            ip       <= '0;
            cause_ip <= '0;
            held_bd  <= 1'b0;
            held_exc <= '0;
        end else begin
            state <= state_next;
            ip    <= ip_src;
            // Mirror whatever was written to Cause so refreshes keep BD/ExcCode.
            if (cause_we) begin
                cause_ip <= cause_wdata[IP_MSB:IP_LSB];
                held_bd  <= cause_wdata[BD_POS];
                held_exc <= cause_wdata[EXC_MSB:EXC_LSB];
            end
        end
    end

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        state_next  = state;
        take        = 1'b0;
        cause_wdata = '0;
        cause_we    = 1'b0;
        epc_wdata   = '0;
        epc_we      = 1'b0;
        exl_set     = 1'b0;
        exl_clr     = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = HANDLER_PC;

        if (reset) begin
            case (state)
                RUN, HANDLER: begin
                    // Interrupts only compete in RUN; exceptions win over ERET.
                    if (m_valid && (m_exc_code != EXC_INT || (state == RUN && int_req))) begin
                        take        = 1'b1;
                        cause_we    = 1'b1;
                        cause_wdata = pack_cause(m_bd, ip, m_exc_code);
                        flush       = 1'b1;
                        redirect    = 1'b1;
                        state_next  = DRAIN_IN;
                        if (state == RUN) begin
                            epc_we    = 1'b1;
                            epc_wdata = m_bd ? (m_pc - 32'd4) : m_pc;
                            exl_set   = 1'b1;
                        end
                    end else if (m_valid && m_eret) begin
                        exl_clr     = 1'b1;
                        flush       = 1'b1;
                        redirect    = 1'b1;
                        redirect_pc = epc_value;
                        state_next  = DRAIN_OUT;
                    end
                    if (!take && ip != cause_ip) begin
                        cause_we    = 1'b1;
                        cause_wdata = pack_cause(held_bd, ip, held_exc);
                    end
                end
                DRAIN_IN:  state_next = HANDLER;
                DRAIN_OUT: state_next = RUN;
                default:   state_next = RUN;
            endcase
        end
    end

endmodule
